// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, header helpers and tx state encoding for the router packet source
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] DEST_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] dest;
  } header_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_HEADER,
    TX_PAYLOAD,
    TX_PARITY,
    TX_GAP
  } tx_state_e;

  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0] len,
                                                    input logic [ADDR_W-1:0] dest);
    return {len, dest};
  endfunction

  function automatic header_t unpack_header(input logic [DATA_W-1:0] hdr);
    return header_t'(hdr);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - host request/payload and router wire signals of the packet source
interface router_pkt_tx_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6,
  parameter int ADDR_W = 2
);
  logic              abort;
  logic              start;
  logic [ADDR_W-1:0] start_dest;
  logic [LEN_W-1:0]  start_len;
  logic              pl_valid;
  logic [DATA_W-1:0] pl_data;
  logic              pl_ready;
  logic              tx_ready;
  logic              router_busy;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              err;

  // master: the packet source itself; slave: host plus router side
  modport master (
    input  abort, start, start_dest, start_len, pl_valid, pl_data, router_busy,
    output pl_ready, tx_ready, pkt_valid, data_out, done, err
  );

  modport slave (
    output abort, start, start_dest, start_len, pl_valid, pl_data, router_busy,
    input  pl_ready, tx_ready, pkt_valid, data_out, done, err
  );
endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - synchronous show-ahead payload FIFO, depth 2**AW
module router_tx_buf #(
  parameter int DATA_W = 8,
  parameter int AW     = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fill;
  logic              do_push;
  logic              do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally at AW bits
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a whole payload, then sends header/payload/parity gaplessly to the router
module router_pkt_tx #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W,
  parameter int ADDR_W = router_pkg::ADDR_W,
  parameter int GAP    = 1
) (
  input logic           clock,
  input logic           resetn,
  router_pkt_tx_if.master bus
);
  import router_pkg::*;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic              run_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] parity_q;
  logic [GW-1:0]     gap_q;
  logic              err_q;
  logic              done_q;

  logic              legal;
  logic              start_ok;
  logic              accept;
  logic              xfer;
  logic              last_cnt;
  logic              gap_last;
  logic              buf_push;
  logic              buf_pop;
  logic [DATA_W-1:0] buf_dout;
  logic              buf_empty;
  logic              buf_full;

  logic              pkt_valid_c;
  logic [DATA_W-1:0] data_c;
  logic              pl_ready_c;
  logic              tx_ready_c;

  assign legal    = (bus.start_dest != ADDR_W'(DEST_ILLEGAL)) && (bus.start_len != '0);
  assign start_ok = (state_q == TX_IDLE) && run_q && bus.start && !bus.abort && legal;
  assign accept   = pl_ready_c && bus.pl_valid;
  assign xfer     = pkt_valid_c && !bus.router_busy;
  assign last_cnt = (count_q == len_q - 1'b1);
  assign gap_last = (gap_q == GW'(GAP - 1));
  assign buf_push = accept && !bus.abort;
  assign buf_pop  = (state_q == TX_PAYLOAD) && xfer && !bus.abort && !buf_empty;

  router_tx_buf #(
    .DATA_W (DATA_W),
    .AW     (LEN_W)
  ) u_buf (
    .clock  (clock),
    .resetn (resetn),
    .push   (buf_push),
    .pop    (buf_pop),
    .flush  (bus.abort),
    .din    (bus.pl_data),
    .dout   (buf_dout),
    .empty  (buf_empty),
    .full   (buf_full)
  );

  // run_q keeps tx_ready low until the first clock after reset release
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= TX_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:    if (start_ok)            state_d = TX_LOAD;
      TX_LOAD:    if (accept && last_cnt)  state_d = TX_HEADER;
      TX_HEADER:  if (xfer)                state_d = TX_PAYLOAD;
      TX_PAYLOAD: if (xfer && last_cnt)    state_d = TX_PARITY;
      TX_PARITY:  if (xfer)                state_d = TX_GAP;
      TX_GAP:     if (gap_last)            state_d = TX_IDLE;
      default:                             state_d = TX_IDLE;
    endcase
    if (bus.abort) begin
      state_d = TX_IDLE;
    end
  end

  always_comb begin
    pkt_valid_c = 1'b0;
    data_c      = '0;
    pl_ready_c  = 1'b0;
    tx_ready_c  = 1'b0;
    case (state_q)
      TX_IDLE:    tx_ready_c = run_q;
      TX_LOAD:    pl_ready_c = !buf_full;
      TX_HEADER: begin
        pkt_valid_c = 1'b1;
        data_c      = {len_q, dest_q};
      end
      TX_PAYLOAD: begin
        pkt_valid_c = 1'b1;
        data_c      = buf_dout;
      end
      TX_PARITY: begin
        pkt_valid_c = 1'b1;
        data_c      = parity_q;
      end
      default: ;
    endcase
  end

  // count_q is reused: accepted bytes in LOAD, popped bytes in PAYLOAD
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      len_q    <= '0;
      dest_q   <= '0;
      count_q  <= '0;
      parity_q <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort) begin
      count_q  <= '0;
      parity_q <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      err_q  <= (state_q == TX_IDLE) && run_q && bus.start && !legal;
      done_q <= (state_q == TX_PARITY) && xfer;
      gap_q  <= ((state_q == TX_GAP) && !gap_last) ? gap_q + 1'b1 : '0;
      case (state_q)
        TX_IDLE: begin
          if (start_ok) begin
            len_q    <= bus.start_len;
            dest_q   <= bus.start_dest;
            parity_q <= '0;
            count_q  <= '0;
          end
        end
        TX_LOAD: begin
          if (accept) begin
            count_q <= last_cnt ? '0 : count_q + 1'b1;
          end
        end
        TX_HEADER: begin
          if (xfer) begin
            parity_q <= parity_q ^ data_c;
          end
        end
        TX_PAYLOAD: begin
          if (xfer) begin
            parity_q <= parity_q ^ buf_dout;
            count_q  <= last_cnt ? '0 : count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pkt_valid = pkt_valid_c;
  assign bus.data_out  = data_c;
  assign bus.pl_ready  = pl_ready_c;
  assign bus.tx_ready  = tx_ready_c;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

  logic clock;
  logic resetn;

  router_pkt_tx_if #(.DATA_W(8), .LEN_W(6), .ADDR_W(2)) bus ();

  router_pkt_tx #(.DATA_W(8), .LEN_W(6), .ADDR_W(2), .GAP(1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wire_q[$];
  int valid_cycles = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;
  int plr_cnt      = 0;
  int cur_run      = 0;
  int last_run     = 0;

  logic [7:0] pl_bytes[$];
  logic [7:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // wire observer; negedge sits mid-cycle, after inputs settle
  always @(negedge clock) begin
    if (bus.pkt_valid && !bus.router_busy) wire_q.push_back(bus.data_out);
    if (bus.pkt_valid) begin
      valid_cycles++;
      cur_run++;
    end else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
    end
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.pl_ready) plr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pkt(input logic [1:0] dest, input logic [5:0] len, input bit toggle);
    int guard;
    bus.start      = 1'b1;
    bus.start_dest = dest;
    bus.start_len  = len;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (toggle) begin
        bus.pl_valid = 1'b0;
        tick();
      end
      bus.pl_valid = 1'b1;
      bus.pl_data  = pl_bytes[i];
      guard = 0;
      while (!bus.pl_ready && guard < 20) begin
        tick();
        guard++;
      end
      tick();
    end
    bus.pl_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int guard = 0;
    while (done_cnt == base && guard < 400) begin
      tick();
      guard++;
    end
    check(tag, done_cnt, base + 1);
  endtask

  task automatic check_wire(input string tag, input int base);
    check({tag, "_len"}, wire_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wire_q.size())
        check($sformatf("%s_b%0d", tag, i), wire_q[base + i], exp_q[i]);
      else
        check($sformatf("%s_b%0d", tag, i), 32'hFFFF_FFFF, exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb, vb, db, eb, pb;
    logic [7:0] par;

    resetn          = 1'b1;
    bus.abort       = 1'b0;
    bus.start       = 1'b0;
    bus.start_dest  = '0;
    bus.start_len   = '0;
    bus.pl_valid    = 1'b0;
    bus.pl_data     = '0;
    bus.router_busy = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_pl_ready", bus.pl_ready, 0);
    check("rst_done_err", {bus.done, bus.err}, 0);
    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
    check("post_rst_tx_ready", bus.tx_ready, 1);

    // 1: basic packet, no busy
    pl_bytes = '{8'h11, 8'h22, 8'h33};
    wb = wire_q.size(); vb = valid_cycles; db = done_cnt;
    load_pkt(2'd1, 6'd3, 1'b0);
    check("t1_hdr_latency_valid", bus.pkt_valid, 1);
    check("t1_hdr_latency_data", bus.data_out, 8'h0D);
    check("t1_pl_ready_low", bus.pl_ready, 0);
    wait_done("t1_done", db);
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    check_wire("t1_wire", wb);
    check("t1_valid_cycles", valid_cycles - vb, 5);
    check("t1_gapless", last_run, 5);
    tick(); tick();
    check("t1_done_once", done_cnt - db, 1);
    check("t1_tx_ready", bus.tx_ready, 1);

    // 2: router busy for two cycles on payload byte 2
    wb = wire_q.size(); vb = valid_cycles; db = done_cnt;
    load_pkt(2'd1, 6'd3, 1'b0);
    tick();
    tick();
    bus.router_busy = 1'b1;
    check("t2_hold0", bus.data_out, 8'h22);
    tick();
    check("t2_hold1", bus.data_out, 8'h22);
    check("t2_hold1_valid", bus.pkt_valid, 1);
    tick();
    bus.router_busy = 1'b0;
    check("t2_hold2", bus.data_out, 8'h22);
    wait_done("t2_done", db);
    check_wire("t2_wire", wb);
    check("t2_valid_cycles", valid_cycles - vb, 7);

    // 3: rejected requests
    eb = err_cnt; pb = plr_cnt;
    bus.start = 1'b1; bus.start_dest = 2'd3; bus.start_len = 6'd4;
    tick();
    bus.start = 1'b0;
    check("t3_err_dest3", bus.err, 1);
    check("t3_tx_ready_dest3", bus.tx_ready, 1);
    tick();
    check("t3_err_pulse", bus.err, 0);
    bus.start = 1'b1; bus.start_dest = 2'd0; bus.start_len = 6'd0;
    tick();
    bus.start = 1'b0;
    check("t3_err_len0", bus.err, 1);
    check("t3_tx_ready_len0", bus.tx_ready, 1);
    tick(); tick();
    check("t3_err_count", err_cnt - eb, 2);
    check("t3_pl_ready_never", plr_cnt - pb, 0);

    // 4: maximum length, host gaps every other cycle
    pl_bytes.delete();
    par = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      pl_bytes.push_back(8'(i * 7 + 3));
      par = par ^ 8'(i * 7 + 3);
    end
    wb = wire_q.size(); vb = valid_cycles; db = done_cnt;
    load_pkt(2'd0, 6'd63, 1'b1);
    check("t4_hdr", bus.data_out, 8'hFC);
    wait_done("t4_done", db);
    exp_q = '{8'hFC};
    for (int i = 0; i < 63; i++) exp_q.push_back(pl_bytes[i]);
    exp_q.push_back(par);
    check_wire("t4_wire", wb);
    check("t4_valid_cycles", valid_cycles - vb, 65);
    check("t4_gapless", last_run, 65);

    // 5: abort on payload byte 5 of 10, then a clean packet
    pl_bytes.delete();
    for (int i = 0; i < 10; i++) pl_bytes.push_back(8'(8'h50 + i));
    db = done_cnt;
    load_pkt(2'd0, 6'd10, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_byte5", bus.data_out, 8'h54);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_abort_valid", bus.pkt_valid, 0);
    check("t5_abort_data", bus.data_out, 0);
    check("t5_abort_tx_ready", bus.tx_ready, 1);
    check("t5_abort_no_done", done_cnt - db, 0);
    bus.start = 1'b1; bus.start_dest = 2'd2; bus.start_len = 6'd1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_abort_beats_start", bus.pl_ready, 0);
    check("t5_abort_beats_start_rdy", bus.tx_ready, 1);
    pl_bytes = '{8'hAA};
    wb = wire_q.size(); db = done_cnt;
    load_pkt(2'd2, 6'd1, 1'b0);
    wait_done("t5_done", db);
    exp_q = '{8'h06, 8'hAA, 8'hAC};
    check_wire("t5_wire", wb);

    // 6: reset asserted while the header is on the wire
    pl_bytes = '{8'h01, 8'h02};
    load_pkt(2'd1, 6'd2, 1'b0);
    check("t6_in_header", bus.pkt_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_valid", bus.pkt_valid, 0);
    check("t6_rst_data", bus.data_out, 0);
    check("t6_rst_tx_ready", bus.tx_ready, 0);
    check("t6_rst_pl_ready", bus.pl_ready, 0);
    #2 resetn = 1'b1;
    tick();
    check("t6_rel_tx_ready", bus.tx_ready, 1);
    pl_bytes = '{8'h11, 8'h22, 8'h33};
    wb = wire_q.size(); db = done_cnt;
    load_pkt(2'd1, 6'd3, 1'b0);
    wait_done("t6_done", db);
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    check_wire("t6_wire", wb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
